// File: rtl/stream_demux_1x2_pkg.sv
// stream_demux_pkg: shared types and constants for the packet-aware 1x2 stream router
package stream_demux_pkg;
  typedef enum logic [1:0] {IDLE, PKT0, PKT1} route_state_t;
  localparam int SKID_DEPTH = 2;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/stream_demux_1x2_if.sv
// stream_demux_1x2_if: valid/ready stream with packet delimiter
interface stream_demux_1x2_if
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic valid;
  logic ready;
  logic last;
  logic [WIDTH-1:0] data;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/stream_demux_1x2_skid_buf.sv
// stream_skid_buf: 2-entry FIFO with registered valid and upstream ready
module stream_skid_buf
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] ent1;
  logic push, pop;
  // occupancy after this edge drives both registered handshake flags
  always_comb begin
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    cnt_nxt = cnt + 2'(push) - 2'(pop);
  end
  // head lives in out_data, second entry in ent1; a full buffer never pushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      out_valid <= 1'b0;
      in_ready <= 1'b1;
      out_data <= '0;
      ent1 <= '0;
    end else begin
      cnt <= cnt_nxt;
      out_valid <= cnt_nxt != 2'd0;
      in_ready <= cnt_nxt < 2'(SKID_DEPTH);
      if (pop && cnt == 2'd2)
        out_data <= ent1;
      else if (push && (cnt == 2'd0 || (pop && cnt == 2'd1)))
        out_data <= in_data;
      if (push && cnt == 2'd1 && !pop)
        ent1 <= in_data;
    end
  end
endmodule

// File: rtl/stream_demux_1x2.sv
// stream_demux_1x2: steers whole packets to one of two skid-buffered outputs
module stream_demux_1x2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 in_sel,
  stream_demux_1x2_if.slave   in_bus,
  stream_demux_1x2_if.master  out0,
  stream_demux_1x2_if.master  out1
);
  route_state_t state;
  logic run, tgt, rdy0, rdy1, acc;
  logic [WIDTH:0] w0, w1;
  // destination is latched by the FSM after the first beat; in_sel only matters at a boundary
  always_comb begin
    tgt = state == PKT1 ? 1'b1 : state == PKT0 ? 1'b0 : in_sel;
    in_bus.ready = run & (tgt ? rdy1 : rdy0);
    acc = in_bus.valid & in_bus.ready;
    {out0.last, out0.data} = w0;
    {out1.last, out1.data} = w1;
  end
  // route FSM plus run flag that blocks acceptance in the reset-release cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      if (acc)
        state <= in_bus.last ? IDLE : tgt ? PKT1 : PKT0;
    end
  end
  stream_skid_buf #(.WIDTH(WIDTH + 1)) u_buf0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_bus.valid & run & ~tgt),
    .in_ready (rdy0),
    .in_data  ({in_bus.last, in_bus.data}),
    .out_valid(out0.valid),
    .out_ready(out0.ready),
    .out_data (w0)
  );
  stream_skid_buf #(.WIDTH(WIDTH + 1)) u_buf1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_bus.valid & run & tgt),
    .in_ready (rdy1),
    .in_data  ({in_bus.last, in_bus.data}),
    .out_valid(out1.valid),
    .out_ready(out1.ready),
    .out_data (w1)
  );
endmodule

// File: tb/tb_stream_demux_1x2.sv
// tb_stream_demux_1x2: directed and random stimulus against a queue-based packet router model
module tb_stream_demux_1x2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_sel = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int dest = -1;
  bit run_m = 1'b0;
  bit a;
  stream_demux_1x2_if #(.WIDTH(8)) in_bus ();
  stream_demux_1x2_if #(.WIDTH(8)) out0 ();
  stream_demux_1x2_if #(.WIDTH(8)) out1 ();
  always #5 clk = ~clk;
  stream_demux_1x2 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_sel(in_sel),
    .in_bus(in_bus),
    .out0  (out0),
    .out1  (out1)
  );
  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // one clock cycle: drive at negedge, check mid-cycle, advance model at posedge
  task automatic cycle(input logic rn, input logic v, input logic s, input logic [7:0] d,
                       input logic l, input logic r0, input logic r1, output bit acc);
    bit tgt, p0, p1, er;
    rst_n = rn;
    in_bus.valid = v;
    in_sel = s;
    in_bus.data = d;
    in_bus.last = l;
    out0.ready = r0;
    out1.ready = r1;
    if (!rn) begin
      q0.delete();
      q1.delete();
      dest = -1;
      run_m = 1'b0;
    end
    #1;
    tgt = (dest < 0) ? s : dest[0];
    er = run_m && (tgt ? q1.size() < 2 : q0.size() < 2);
    chk("in_ready", 9'(in_bus.ready), 9'(er));
    chk("out0_valid", 9'(out0.valid), 9'(q0.size() > 0));
    chk("out1_valid", 9'(out1.valid), 9'(q1.size() > 0));
    if (q0.size() > 0) chk("out0_beat", {out0.last, out0.data}, q0[0]);
    else if (!rn) chk("out0_rst", {out0.last, out0.data}, 9'h0);
    if (q1.size() > 0) chk("out1_beat", {out1.last, out1.data}, q1[0]);
    else if (!rn) chk("out1_rst", {out1.last, out1.data}, 9'h0);
    acc = rn && v && er;
    p0 = rn && r0 && q0.size() > 0;
    p1 = rn && r1 && q1.size() > 0;
    @(posedge clk);
    if (rn) begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (tgt) q1.push_back({l, d});
        else q0.push_back({l, d});
        dest = l ? -1 : int'(tgt);
      end
      run_m = 1'b1;
    end
    @(negedge clk);
  endtask
  task automatic send(input logic s, input logic [7:0] d, input logic l, input logic r0, input logic r1);
    bit acc;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, s, d, l, r0, r1, acc);
      if (acc) return;
    end
    chk("send_timeout", 9'h0, 9'h1);
  endtask
  task automatic idle(input int n, input logic r0, input logic r1);
    bit acc;
    repeat (n) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1, acc);
  endtask
  initial begin
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, a);
    cycle(1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, a);
    chk("release_no_accept", 9'(a), 9'h0);
    send(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
    send(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    send(1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
    send(1'b0, 8'h02, 1'b0, 1'b1, 1'b1);
    send(1'b0, 8'h03, 1'b0, 1'b1, 1'b1);
    send(1'b0, 8'h04, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    send(1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 1'b1, a);
    send(1'b0, 8'h12, 1'b0, 1'b1, 1'b1);
    send(1'b0, 8'h13, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    send(1'b0, 8'h20, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h21, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h22 + i), i == 3, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b1);
    idle(3, 1'b1, 1'b1);
    repeat (400)
      cycle(1'b1, 1'(~$urandom_range(0, 3) == 0 ? 1 : 0), 1'($urandom), 8'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), a);
    idle(4, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b0, 8'(8'h50 + i), i == 5, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    send(1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h31, 1'b0, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 8'h32, 1'b0, 1'b0, 1'b1, a);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
    send(1'b1, 8'h40, 1'b0, 1'b1, 1'b1);
    send(1'b1, 8'h41, 1'b0, 1'b1, 1'b1);
    send(1'b1, 8'h42, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);
    chk("drained0", 9'(q0.size()), 9'h0);
    chk("drained1", 9'(q1.size()), 9'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/stream_demux_1x2.md
# stream_demux_1x2

Packet-aware 1-to-2 stream router: accepts a valid/ready stream and steers each whole packet, delimited by `last`, to one of two output streams. The destination is selected by `in_sel` on the first beat of the packet. This block is the clocked successor of the combinational 1x2 demultiplexer and sits between a single producer and two downstream consumers. Each output has a 2-entry skid buffer, so the block sustains full throughput and isolates backpressure per output.

## Interface
- `WIDTH`, default 8: data width in bits, ≥1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream beat valid.
- `in_ready` output 1: upstream beat accepted when `in_valid & in_ready` at the rising edge.
- `in_data` input WIDTH: beat payload.
- `in_last` input 1: final beat of the packet.
- `in_sel` input 1: destination (0 selects out0, 1 selects out1); sampled only on the first beat of a packet.
- `out0_valid`, `out1_valid` output 1: output beat valid.
- `out0_ready`, `out1_ready` input 1: downstream ready.
- `out0_data`, `out1_data` output WIDTH: output payload.
- `out0_last`, `out1_last` output 1: output packet delimiter.

## Operation
- **Route FSM** has three states:
  - IDLE: at a packet boundary.
  - PKT0: mid-packet, routing to out0.
  - PKT1: mid-packet, routing to out1.
- **IDLE behaviour:**
  - Route target = `in_sel`.
  - An accepted beat with `in_last=0` moves the FSM to PKT0 or PKT1 per `in_sel`.
  - An accepted beat with `in_last=1` (single-beat packet) keeps the FSM in IDLE.
- **PKTx behaviour:**
  - Route target = x; `in_sel` is ignored.
  - An accepted beat with `in_last=1` returns the FSM to IDLE.
  - Otherwise the FSM holds in PKTx.
- **Ready and writes:**
  - `in_ready` = `run` & ready of the targeted skid buffer. The non-targeted output never stalls the input.
  - An accepted beat writes `{data,last}` into the targeted buffer only.
- **Skid buffer** (per output):
  - 2 entries; `outX_valid` and the buffer's upstream ready are registered.
  - Upstream ready = fewer than 2 entries held.
  - Data and last are presented unmodified and in order.
- **`run` flag:**
  - Reset to 0.
  - Set on the first rising edge after `rst_n` deasserts.
  - Prevents acceptance in the release cycle.
- **Reset values** (asynchronous, applied while `rst_n=0`):
  - FSM = IDLE, `run=0`.
  - Both buffers empty.
  - `in_ready=0`, `out0_valid=out1_valid=0`, `out0_data=out1_data=0`, `out0_last=out1_last=0`.
- **Reset mid-packet:** the partial packet is discarded in both buffers and the FSM. No resynchronisation to a later `last` is attempted.

## Timing
- **Latency:** a beat accepted at edge k drives `outX_valid=1` with its data from edge k. The downstream consumer can take it at edge k+1.
- **Throughput:** 1 beat/cycle per packet when the targeted `outX_ready` is held high.
- **Stall and refill:**
  - If `outX_ready` drops, the buffer absorbs up to 2 beats, then `in_ready` falls.
  - `in_ready` rises the cycle after one entry drains.
- **Valid/data stability:** `outX_valid` and `outX_data` are held stable while `outX_valid & ~outX_ready`.
- **Simultaneous push and pop** on the same buffer: the occupancy count is unchanged and FIFO order is preserved.
- **Overlapping packets:** a packet to out1 may start while out0 still holds buffered beats of the previous packet.
- **Input stability requirement:** `in_sel` change mid-packet has no effect; `in_valid` dropping mid-packet holds the FSM.

## Structure
- **Package `stream_demux_pkg`:**
  - `route_state_t` enum {IDLE, PKT0, PKT1}.
  - Localparam `SKID_DEPTH = 2`.
  - Localparam `DEFAULT_WIDTH = 8`.
- **Sub-module `stream_skid_buf`:**
  - Parameter `WIDTH`.
  - Valid/ready in and out.
  - Asynchronous active-low reset.
  - Instantiated twice with payload width WIDTH+1 (`{last,data}`).
- **Top level:** FSM, `run` flag, and the in_ready/write-enable steering only.

## Test plan
- **Reset and release:** hold `rst_n=0` with `in_valid=1`, then release.
  - During reset: all outputs 0 and `in_ready=0`.
  - `in_ready=1` from the first edge after release.
- **Single-beat packets:** `in_sel=0,data=8'hA5,last=1`, then `in_sel=1,data=8'h3C,last=1`, both outputs ready.
  - out0 shows A5/last=1 the cycle after acceptance; out1 shows 3C/last=1 one cycle later.
  - No cross-leakage between outputs.
- **Sticky select:** 4-beat packet 01,02,03,04 with `in_sel=1` on beat 1 and `in_sel=0` on beats 2-4.
  - All four beats appear on out1 at 1 beat/cycle; `last` only on 04.
  - out0 stays idle.
- **Backpressure:** `out0_ready=0` while streaming to out0.
  - Exactly 2 beats accepted, then `in_ready=0`.
  - Raise `out0_ready`: beats drain in order, and `in_ready` returns the cycle after the first pop.
- **Isolation:** out0 full and stalled, then a new packet with `in_sel=1`.
  - The out1 packet flows at full rate; out0 contents are unchanged.
- **Reset mid-packet:** assert `rst_n=0` after beat 2 of a 5-beat packet.
  - Outputs clear immediately.
  - The next packet, with `in_sel=1`, routes correctly from IDLE.
